// File: rtl/mem_split_arbiter_pkg.sv
// Shared types for the split-transaction memory arbiter.
// Host IDs, grant FSM states and the arbitration helper.
package mem_split_arbiter_pkg;

  localparam logic HOST_INSTR = 1'b0;
  localparam logic HOST_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_e;

  function automatic state_e arb_pick(
    input logic elig_i,
    input logic elig_d,
    input logic last
  );
    state_e s;
    s = IDLE;
    if (elig_i && elig_d)
      s = (last == HOST_INSTR) ? GRANT_D : GRANT_I;
    else if (elig_i)
      s = GRANT_I;
    else if (elig_d)
      s = GRANT_D;
    return s;
  endfunction

endpackage

// File: rtl/mem_split_arbiter_id_fifo.sv
// In-order FIFO of 1-bit host IDs for outstanding reads.
// almost_full lets the arbiter see a push that fills it.
module arb_id_fifo #(
  parameter int RESP_FIFO_POW = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty,
  output logic almost_full
);

  localparam int PW    = RESP_FIFO_POW;
  localparam int CW    = RESP_FIFO_POW + 1;
  localparam int DEPTH = 1 << RESP_FIFO_POW;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full        = cnt_q == CW'(DEPTH);
  assign almost_full = cnt_q == CW'(DEPTH - 1);
  assign empty       = cnt_q == '0;
  assign head_id     = mem_q[rd_q];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d   = mem_q;
    if (do_push)
      mem_d[wr_q] = push_id;
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_split_arbiter.sv
// Round-robin instr/data arbiter onto one split-transaction port.
// Read responses are steered back in order via an ID FIFO.
module mem_split_arbiter
  import mem_split_arbiter_pkg::*;
#(
  parameter int RESP_FIFO_POW = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req,
  input  logic        instr_we,
  input  logic [31:0] instr_addr,
  input  logic [31:0] instr_wdata,
  input  logic [3:0]  instr_be,
  output logic        instr_ack,
  output logic        instr_resp,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_ack,
  output logic        data_resp,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   err_q, err_d;
  logic   full, empty, afull, head_id;
  logic   push, push_id, pop;
  logic   grant_i, grant_d, accept, rd_block;
  logic   elig_i, elig_d;

  assign grant_i = state_q == GRANT_I;
  assign grant_d = state_q == GRANT_D;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_i) begin
      mem_req   = instr_req;
      mem_we    = instr_we;
      mem_addr  = instr_addr;
      mem_wdata = instr_wdata;
      mem_be    = instr_be;
    end else if (grant_d) begin
      mem_req   = data_req;
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_be    = data_be;
    end
  end

  always_comb begin
    accept    = mem_req & mem_ack;
    instr_ack = accept & grant_i;
    data_ack  = accept & grant_d;
    push_id   = grant_d ? HOST_DATA : HOST_INSTR;
    push      = accept & ~mem_we;
    // a read accepted this cycle may fill the FIFO
    rd_block  = full | (push & afull);
    elig_i    = instr_req & ~(~instr_we & rd_block);
    elig_d    = data_req & ~(~data_we & rd_block);
    last_d    = accept ? push_id : last_q;
    if (mem_req && !mem_ack)
      state_d = state_q;
    else
      state_d = arb_pick(elig_i, elig_d, last_d);
  end

  always_comb begin
    pop         = mem_resp & ~empty;
    instr_resp  = pop & (head_id == HOST_INSTR);
    data_resp   = pop & (head_id == HOST_DATA);
    err_d       = err_q | (mem_resp & empty);
    instr_rdata = mem_rdata;
    data_rdata  = mem_rdata;
  end

  assign resp_err = err_q;

  arb_id_fifo #(
    .RESP_FIFO_POW(RESP_FIFO_POW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (push),
    .push_id    (push_id),
    .pop        (pop),
    .head_id    (head_id),
    .full       (full),
    .empty      (empty),
    .almost_full(afull)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= HOST_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_split_arbiter.sv
// Self-checking bench for mem_split_arbiter.
// Directed scenarios plus a randomized run against a queue model.
module tb_mem_split_arbiter;

  localparam int POW   = 2;
  localparam int DEPTH = 1 << POW;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        instr_req, instr_we, instr_ack, instr_resp;
  logic [31:0] instr_addr, instr_wdata, instr_rdata;
  logic [3:0]  instr_be;
  logic        data_req, data_we, data_ack, data_resp;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic        mem_req, mem_we, mem_ack, mem_resp, resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_split_arbiter #(.RESP_FIFO_POW(POW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req(instr_req), .instr_we(instr_we),
    .instr_addr(instr_addr), .instr_wdata(instr_wdata),
    .instr_be(instr_be), .instr_ack(instr_ack),
    .instr_resp(instr_resp), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_ack(data_ack),
    .data_resp(data_resp), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .resp_err(resp_err)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_we = 0; instr_addr = 0;
    instr_wdata = 0; instr_be = 0;
    data_req = 0; data_we = 0; data_addr = 0;
    data_wdata = 0; data_be = 0;
    mem_ack = 0; mem_resp = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 0;
    repeat (2) tick();
    rst_i = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    instr_req = 1;
    data_req = 1;
    settle();
    checks++;
    if ({mem_req, instr_ack, data_ack, instr_resp, data_resp,
         resp_err, mem_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {mem_req, instr_ack,
               data_ack, instr_resp, data_resp, resp_err, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0",
               {mem_addr, mem_wdata, mem_be});
    end
    do_reset();
  endtask

  task automatic test_single_read();
    int iack, iresp, dresp;
    logic [31:0] got;
    do_reset();
    iack = 0; iresp = 0; dresp = 0; got = 0;
    instr_req = 1; instr_we = 0; instr_addr = 32'h100; instr_be = 4'hf;
    settle();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL single_latency got=%b exp=0", mem_req);
    end
    tick();
    mem_ack = 1;
    settle();
    checks++;
    if ({mem_req, instr_ack, data_ack} !== 3'b110 ||
        mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL single_grant got=%b/%h exp=110/100",
               {mem_req, instr_ack, data_ack}, mem_addr);
    end
    iack += int'(instr_ack);
    for (int c = 2; c < 8; c++) begin
      tick();
      instr_req = 0; mem_ack = 0;
      mem_resp  = (c == 4);
      mem_rdata = (c == 4) ? 32'hdeadbeef : 32'h0;
      settle();
      iack  += int'(instr_ack);
      iresp += int'(instr_resp);
      dresp += int'(data_resp);
      if (instr_resp) got = instr_rdata;
    end
    checks++;
    if (iack != 1 || iresp != 1 || dresp != 0) begin
      failures++;
      $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/0",
               iack, iresp, dresp);
    end
    checks++;
    if (got !== 32'hdeadbeef) begin
      failures++;
      $display("FAIL single_rdata got=%h exp=deadbeef", got);
    end
  endtask

  task automatic test_alternate();
    int icnt, dcnt;
    logic [1:0]  exp_ack;
    logic [31:0] exp_addr;
    do_reset();
    icnt = 0; dcnt = 0;
    instr_req = 1; instr_addr = 32'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      instr_req  = icnt < 2;
      instr_addr = 32'h10 + 32'(icnt * 4);
      data_req   = dcnt < 2;
      data_addr  = 32'h20 + 32'(dcnt * 4);
      mem_ack    = 1;
      settle();
      exp_ack  = (c == 5) ? 2'b00 : ((c % 2 == 1) ? 2'b10 : 2'b01);
      exp_addr = (c % 2 == 1) ? 32'h10 + 32'(((c - 1) / 2) * 4)
                              : 32'h20 + 32'(((c - 2) / 2) * 4);
      checks++;
      if ({instr_ack, data_ack} !== exp_ack ||
          (c < 5 && mem_addr !== exp_addr)) begin
        failures++;
        $display("FAIL alt_grant c=%0d got=%b/%h exp=%b/%h", c,
                 {instr_ack, data_ack}, mem_addr, exp_ack, exp_addr);
      end
      icnt += int'(instr_ack);
      dcnt += int'(data_ack);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      instr_req = 0; data_req = 0; mem_ack = 0;
      mem_resp = 1; mem_rdata = 32'(k + 1);
      settle();
      checks++;
      if ({instr_resp, data_resp} !== ((k % 2 == 0) ? 2'b10 : 2'b01) ||
          instr_rdata !== 32'(k + 1) || data_rdata !== 32'(k + 1)) begin
        failures++;
        $display("FAIL alt_resp k=%0d got=%b/%h", k,
                 {instr_resp, data_resp}, instr_rdata);
      end
    end
    tick();
    mem_resp = 0;
    settle();
    checks++;
    if (resp_err !== 1'b0) begin
      failures++;
      $display("FAIL alt_err got=%b exp=0", resp_err);
    end
  endtask

  task automatic test_write_then_read();
    int dack, iack, iresp, dresp;
    do_reset();
    data_req = 1; data_we = 1; data_addr = 32'h200;
    data_wdata = 32'ha5a5; data_be = 4'b0011;
    tick();
    mem_ack = 1;
    settle();
    checks++;
    if ({data_ack, mem_we} !== 2'b11 || mem_be !== 4'b0011 ||
        mem_wdata !== 32'ha5a5 || mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL wr_bus got=%b/%b/%h/%h", {data_ack, mem_we},
               mem_be, mem_wdata, mem_addr);
    end
    dack = int'(data_ack); iack = 0; iresp = 0; dresp = 0;
    for (int c = 2; c < 10; c++) begin
      tick();
      data_req   = 0;
      instr_req  = (iack == 0);
      instr_we   = 0;
      instr_addr = 32'h300;
      mem_resp   = (c == 7) || (c == 8);
      mem_rdata  = 32'h1234;
      settle();
      dack  += int'(data_ack);
      iack  += int'(instr_ack);
      iresp += int'(instr_resp);
      dresp += int'(data_resp);
    end
    checks++;
    if (dack != 1 || iack != 1 || iresp != 1 || dresp != 0) begin
      failures++;
      $display("FAIL wr_counts got=%0d/%0d/%0d/%0d exp=1/1/1/0",
               dack, iack, iresp, dresp);
    end
    checks++;
    if (resp_err !== 1'b1) begin
      failures++;
      $display("FAIL wr_no_push got=%b exp=1", resp_err);
    end
  endtask

  task automatic test_fifo_full();
    int icnt, iack, dack;
    do_reset();
    icnt = 0; iack = 0; dack = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      instr_req  = icnt < 4;
      instr_we   = 0;
      instr_addr = 32'h400 + 32'(icnt * 4);
      mem_ack    = 1;
      settle();
      icnt += int'(instr_ack);
    end
    checks++;
    if (icnt != 4) begin
      failures++;
      $display("FAIL full_fill got=%0d exp=4", icnt);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      instr_req = 1; instr_addr = 32'h500;
      data_req = (dack == 0); data_we = 1; data_addr = 32'h600;
      settle();
      iack += int'(instr_ack);
      dack += int'(data_ack);
    end
    checks++;
    if (iack != 0 || dack != 1) begin
      failures++;
      $display("FAIL full_block got=%0d/%0d exp=0/1", iack, dack);
    end
    tick();
    data_req = 0; mem_resp = 1; mem_rdata = 32'h77;
    settle();
    checks++;
    if ({instr_ack, instr_resp} !== 2'b01) begin
      failures++;
      $display("FAIL full_pop got=%b exp=01", {instr_ack, instr_resp});
    end
    tick();
    mem_resp = 0;
    settle();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL full_p1 got=%b exp=0", mem_req);
    end
    tick();
    settle();
    checks++;
    if ({mem_req, instr_ack} !== 2'b11 || mem_addr !== 32'h500) begin
      failures++;
      $display("FAIL full_regrant got=%b/%h exp=11/500",
               {mem_req, instr_ack}, mem_addr);
    end
  endtask

  task automatic test_resp_err();
    do_reset();
    mem_resp = 1;
    settle();
    checks++;
    if ({instr_resp, data_resp} !== 2'b00) begin
      failures++;
      $display("FAIL err_noresp got=%b exp=00", {instr_resp, data_resp});
    end
    tick();
    mem_resp = 0;
    settle();
    checks++;
    if (resp_err !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b exp=1", resp_err);
    end
    repeat (5) tick();
    checks++;
    if (resp_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", resp_err);
    end
    rst_i = 0;
    #1;
    checks++;
    if (resp_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b exp=0", resp_err);
    end
    tick();
    rst_i = 1;
  endtask

  task automatic test_reset_mid();
    int icnt;
    do_reset();
    icnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      instr_req  = 1;
      instr_we   = 0;
      instr_addr = 32'h700 + 32'(icnt * 4);
      mem_ack    = icnt < 3;
      settle();
      icnt += int'(instr_ack);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h70c || icnt != 3) begin
      failures++;
      $display("FAIL mid_setup got=%b/%h/%0d exp=1/70c/3",
               mem_req, mem_addr, icnt);
    end
    rst_i = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_req got=%b exp=0", mem_req);
    end
    idle_inputs();
    tick();
    tick();
    rst_i = 1;
    tick();
    settle();
    checks++;
    if ({mem_req, resp_err} !== 2'b00) begin
      failures++;
      $display("FAIL mid_idle got=%b exp=00", {mem_req, resp_err});
    end
    tick();
    mem_resp = 1;
    settle();
    checks++;
    if ({instr_resp, data_resp} !== 2'b00) begin
      failures++;
      $display("FAIL mid_stray got=%b exp=00", {instr_resp, data_resp});
    end
    tick();
    mem_resp = 0;
    settle();
    checks++;
    if (resp_err !== 1'b1) begin
      failures++;
      $display("FAIL mid_err got=%b exp=1", resp_err);
    end
  endtask

  task automatic test_random();
    int   owner, last, n0;
    bit   q[$];
    bit   ip, dp, err_m, exp_req, acc, acc_we, pushing, blocked;
    bit   ei, ed, h, exp_ir, exp_dr;
    logic [31:0] exp_addr;
    do_reset();
    owner = -1; last = 0; err_m = 0; ip = 0; dp = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1;
        instr_we    = $urandom_range(0, 3) == 0;
        instr_addr  = $urandom;
        instr_wdata = $urandom;
        instr_be    = 4'($urandom);
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1;
        data_we    = $urandom_range(0, 1) == 0;
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_be    = 4'($urandom);
      end
      instr_req = ip;
      data_req  = dp;
      mem_ack   = $urandom_range(0, 1) == 1;
      mem_resp  = (q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                 : (c > 500 && $urandom_range(0, 30) == 0);
      mem_rdata = $urandom;
      settle();
      exp_req  = (owner == 0) ? instr_req : (owner == 1) ? data_req : 0;
      exp_addr = (owner == 0) ? instr_addr : data_addr;
      acc      = exp_req && mem_ack;
      acc_we   = (owner == 0) ? instr_we : data_we;
      exp_ir = 0; exp_dr = 0;
      n0 = q.size();
      checks++;
      if (resp_err !== err_m) begin
        failures++;
        $display("FAIL rnd_err c=%0d got=%b exp=%b", c, resp_err, err_m);
      end
      if (mem_resp) begin
        if (n0 == 0) err_m = 1;
        else begin
          h = q.pop_front();
          if (h) exp_dr = 1; else exp_ir = 1;
        end
      end
      pushing = acc && !acc_we;
      if (pushing) q.push_back(owner == 1);
      checks++;
      if ({mem_req, instr_ack, data_ack, instr_resp, data_resp} !==
          {exp_req, acc && owner == 0, acc && owner == 1, exp_ir, exp_dr})
      begin
        failures++;
        $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
                 {mem_req, instr_ack, data_ack, instr_resp, data_resp},
                 {exp_req, acc && owner == 0, acc && owner == 1,
                  exp_ir, exp_dr});
      end
      if (exp_req) begin
        checks++;
        if (mem_addr !== exp_addr || mem_we !== acc_we) begin
          failures++;
          $display("FAIL rnd_bus c=%0d got=%h/%b exp=%h/%b", c,
                   mem_addr, mem_we, exp_addr, acc_we);
        end
      end
      blocked = (n0 == DEPTH) || (pushing && n0 == DEPTH - 1);
      ei = instr_req && !(!instr_we && blocked);
      ed = data_req && !(!data_we && blocked);
      if (acc) last = owner;
      if (acc && owner == 0) ip = 0;
      if (acc && owner == 1) dp = 0;
      if (!(exp_req && !mem_ack))
        owner = (ei && ed) ? ((last == 0) ? 1 : 0)
              : ei ? 0 : ed ? 1 : -1;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_then_read();
    test_fifo_full();
    test_resp_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
